// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM state encoding,
// opcode constants, alu_op encoding (shared with the ALU-control decoder),
// datapath mux select encodings and the one-hot opcode class struct.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] Funct3Beq = 3'b000;

  // alu_op, decoded further by the ALU-control block
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut  = 2'b00;
  localparam logic [1:0] ResMemData = 2'b01;
  localparam logic [1:0] ResAluLive = 2'b10;

  localparam logic AdrPc     = 1'b0;
  localparam logic AdrAluOut = 1'b1;

  // Exactly one bit is set for any opcode/funct3 combination.
  typedef struct packed {
    logic load;
    logic store;
    logic rtype;
    logic itype;
    logic beq;
    logic jal;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational instruction classifier for the multicycle control FSM.
// Ports:
//   opcode_i   - instruction bits [6:0]
//   funct3_i   - instruction bits [14:12]
//   op_class_o - one-hot class: load, store, rtype, itype, beq, jal, illegal
module mc_opcode_class
  import riscv_mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output op_class_t  op_class_o
);

  always_comb begin
    op_class_o = '0;
    case (opcode_i)
      OpLoad:   op_class_o.load  = 1'b1;
      OpStore:  op_class_o.store = 1'b1;
      OpRtype:  op_class_o.rtype = 1'b1;
      OpItype:  op_class_o.itype = 1'b1;
      // Only beq is implemented; other branch funct3 values trap.
      OpBranch: begin
        if (funct3_i == Funct3Beq) op_class_o.beq = 1'b1;
        else                       op_class_o.illegal = 1'b1;
      end
      OpJal:    op_class_o.jal = 1'b1;
      default:  op_class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Sequences the shared ALU, the
// unified memory port and the register file through fetch/decode/execute/
// memory/writeback. Outputs are Moore-decoded from the state register, except
// pc_write in BEQ (follows zero) and the mem_ready-gated FETCH/MEMWR outputs.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   opcode, funct3      - instruction register fields
//   zero                - ALU zero flag (same cycle)
//   mem_ready           - memory completes the current access this cycle
//   mem_req, mem_write  - memory request / store qualifier
//   adr_src             - memory address select (PC / ALUOut)
//   ir_write, pc_write  - IR+OldPC load, PC load
//   reg_write           - register file write enable
//   alu_src_a/b, alu_op - ALU operand selects and ALU-control encoding
//   result_src          - result mux select
//   instr_retired       - one-cycle pulse in an instruction's last cycle
//   illegal_instr       - sticky trap flag, cleared only by reset
module multicycle_ctrl
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal_instr
);

  state_e    state_q, state_d;
  op_class_t op_class;

  mc_opcode_class u_opcode_class (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .op_class_o (op_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (1'b1)
          op_class.load,
          op_class.store:   state_d = StMemAdr;
          op_class.rtype:   state_d = StExecR;
          op_class.itype:   state_d = StExecI;
          op_class.beq:     state_d = StBeq;
          op_class.jal:     state_d = StJal;
          op_class.illegal: state_d = StTrap;
          default:          state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = op_class.store ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExecR,
      StExecI:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBeq:    state_d = StFetch;
      StJal:    state_d = StAluWb;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = AdrPc;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SrcAPc;
    alu_src_b     = SrcBRs2;
    alu_op        = AluOpAdd;
    result_src    = ResAluOut;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SrcBFour;
        result_src = ResAluLive;
      end
      StDecode: begin
        // Branch target OldPC + imm lands in ALUOut for a later BEQ.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRd: begin
        mem_req = 1'b1;
        adr_src = AdrAluOut;
      end
      StMemWb: begin
        result_src    = ResMemData;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      StMemWr: begin
        mem_req       = 1'b1;
        mem_write     = 1'b1;
        adr_src       = AdrAluOut;
        instr_retired = mem_ready;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      StBeq: begin
        alu_src_a     = SrcARs1;
        alu_op        = AluOpSub;
        pc_write      = zero;
        instr_retired = 1'b1;
      end
      StJal: begin
        // PC <- branch target from DECODE; ALU computes OldPC + 4 for rd.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
      end
      StTrap:  illegal_instr = 1'b1;
      default: illegal_instr = 1'b1;
    endcase
  end

endmodule
